// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encoding, S-box and GF(2^8) helpers for encrypt_core.
// Byte 0 of a state word sits in bits [127:120]; bytes are column-major.
package aes_pkg;

  localparam int         NUM_ROUNDS = 10;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  // Row n of the table holds S(16n) .. S(16n+15); index 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/encrypt_core_if.sv
// Request/result bundle between a block driver and encrypt_core.
// The abort line exists only when ENCRYPT_ABORT_EN is defined.
interface encrypt_core_if;
  import aes_pkg::*;

  logic       start;
  aes_state_t plaintext;
  aes_state_t round_key;
  logic [3:0] round_idx;
  logic       busy;
  logic       done;
  aes_state_t ciphertext;
`ifdef ENCRYPT_ABORT_EN
  logic       abort;
`endif

  modport master (
`ifdef ENCRYPT_ABORT_EN
    output abort,
`endif
    output start, plaintext, round_key,
    input  round_idx, busy, done, ciphertext
  );

  modport slave (
`ifdef ENCRYPT_ABORT_EN
    input  abort,
`endif
    input  start, plaintext, round_key,
    output round_idx, busy, done, ciphertext
  );

endinterface

// File: rtl/encrypt_round.sv
// One purely combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// MixColumns is skipped when last_round_i is high.
module encrypt_round
  import aes_pkg::*;
(
  input  aes_state_t state_i,
  input  aes_state_t round_key_i,
  input  logic       last_round_i,
  output aes_state_t state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R = i % 4;
    localparam int C = i / 4;

    assign sb[i] = sbox(state_i[127-8*i -: 8]);
    // Row R rotates left by R columns.
    assign sr[i] = sb[R + 4*((C + R) % 4)];
    assign state_o[127-8*i -: 8] = (last_round_i ? sr[i] : mc[i]) ^ round_key_i[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];

    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/encrypt_core.sv
// Iterative AES-128 encryptor, one round per cycle: done 10 cycles after the start edge,
// start ignored while busy. ENCRYPT_ABORT_EN adds an abort input that cancels a block.
module encrypt_core
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          n_rst,
  encrypt_core_if.slave bus
);

  fsm_state_t fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  aes_state_t blk_q, blk_d;
  aes_state_t ct_q, ct_d;
  aes_state_t round_out;
  logic       abort_w;
  logic       accept;

`ifdef ENCRYPT_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Abort beats start even when idle, so a simultaneous pair starts nothing.
  assign accept = bus.start & ~abort_w;

  encrypt_round u_round (
    .state_i      (blk_q),
    .round_key_i  (bus.round_key),
    .last_round_i (cnt_q == LAST_ROUND),
    .state_o      (round_out)
  );

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
    ct_d  = ct_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (accept) begin
          blk_d = bus.plaintext ^ bus.round_key;
          cnt_d = 4'd1;
          fsm_d = ROUND;
        end else begin
          fsm_d = IDLE;
        end
      end
      ROUND: begin
        if (abort_w) begin
          blk_d = '0;
          cnt_d = 4'd0;
          fsm_d = IDLE;
        end else begin
          blk_d = round_out;
          if (cnt_q == LAST_ROUND) begin
            ct_d  = round_out;
            cnt_d = 4'd0;
            fsm_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q <= IDLE;
      cnt_q <= 4'd0;
      blk_q <= '0;
      ct_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      ct_q  <= ct_d;
    end
  end

  assign bus.busy       = (fsm_q == ROUND);
  assign bus.done       = (fsm_q == DONE);
  assign bus.round_idx  = (fsm_q == ROUND) ? cnt_q : 4'd0;
  assign bus.ciphertext = ct_q;

endmodule

// File: tb/tb_encrypt_core.sv
// Directed bench for encrypt_core using the FIPS-197 example vectors and key schedules.
// Build with ENCRYPT_ABORT_EN defined to include the abort scenarios.
module tb_encrypt_core;

  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam logic [127:0] KA [11] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  localparam logic [127:0] KB [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk = 1'b0;
  logic n_rst;
  logic vsel;
  int   checks = 0;
  int   errors = 0;

  encrypt_core_if bus();

  encrypt_core dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] key_of(input logic s, input logic [3:0] idx);
    if (idx > 4'd10) return '0;
    return s ? KB[idx] : KA[idx];
  endfunction

  assign bus.round_key = key_of(vsel, bus.round_idx);
  assign bus.plaintext = vsel ? PB : PA;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge, then follows the block until done or a 20-cycle budget.
  task automatic run_block(input logic s, input bit pulse,
                           output int lat, output int busy_n, output int idx_bad);
    vsel = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    busy_n = 0;
    idx_bad = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.busy) busy_n++;
      if (bus.round_idx !== 4'(n)) idx_bad++;
      if (pulse) bus.start = n[0];
      tick();
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_block(input string tag, input logic s, input bit pulse);
    int lat, bn, ib;
    run_block(s, pulse, lat, bn, ib);
    chk({tag, "_latency"}, 128'(lat), 128'd10);
    chk({tag, "_busy_cycles"}, 128'(bn), 128'd10);
    chk({tag, "_round_idx_seq_errs"}, 128'(ib), 128'd0);
    chk({tag, "_ciphertext"}, bus.ciphertext, s ? CB : CA);
    chk({tag, "_idx_in_done"}, 128'(bus.round_idx), 128'd0);
    chk({tag, "_busy_in_done"}, 128'(bus.busy), 128'd0);
    tick();
    chk({tag, "_done_one_cycle"}, 128'(bus.done), 128'd0);
  endtask

  initial begin
    int lat;
    bit got;
    bit seen;

    n_rst = 1'b0;
    bus.start = 1'b0;
    vsel = 1'b0;
`ifdef ENCRYPT_ABORT_EN
    bus.abort = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_round_idx", 128'(bus.round_idx), 128'd0);
    chk("rst_ciphertext", bus.ciphertext, 128'd0);
    n_rst = 1'b1;
    tick();

    check_block("vecA", 1'b0, 1'b0);
    check_block("vecB", 1'b1, 1'b0);

    // Start held high: blocks alternate A/B, one result every 11 cycles.
    vsel = 1'b0;
    bus.start = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        tick();
        if (bus.done) begin
          lat = n;
          break;
        end
      end
      chk("b2b_period", 128'(lat), (b == 0) ? 128'd10 : 128'd11);
      chk("b2b_ciphertext", bus.ciphertext, vsel ? CB : CA);
      vsel = ~vsel;
    end
    bus.start = 1'b0;
    tick();
    tick();
    chk("b2b_back_to_idle", 128'(bus.busy), 128'd0);

    check_block("pulses", 1'b0, 1'b1);
    tick();
    chk("pulses_not_queued", 128'(bus.busy), 128'd0);

    // Reset in the middle of round 5.
    vsel = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.round_idx == 4'd5) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_round5", 128'(got), 128'd1);
    n_rst = 1'b0;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_done", 128'(bus.done), 128'd0);
    chk("midrst_round_idx", 128'(bus.round_idx), 128'd0);
    chk("midrst_ciphertext", bus.ciphertext, 128'd0);
    tick();
    tick();
    n_rst = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk("midrst_no_done", 128'(seen), 128'd0);
    check_block("post_rst", 1'b1, 1'b0);

`ifdef ENCRYPT_ABORT_EN
    vsel = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.round_idx == 4'd3) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_round3", 128'(got), 128'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 128'(bus.busy), 128'd0);
    chk("abort_round_idx", 128'(bus.round_idx), 128'd0);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk("abort_no_done", 128'(seen), 128'd0);
    chk("abort_ct_kept", bus.ciphertext, CB);

    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_start_busy", 128'(bus.busy), 128'd0);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("abort_start_nothing", 128'(seen), 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
